// File: rtl/pipeline_controller.sv
// ---------------------------------------------------------------------------
// pipeline_controller
//   Stall/flush sequencer for the 5-stage pipeline. Looks at decode, execute
//   and memory stage status and produces hold/bubble/flush controls for the
//   fetch/decode and decode/execute pipeline registers. It handles load-use
//   hazards, taken-branch flushes, multi-cycle MUL occupancy of execute and
//   data-memory wait states. It also keeps a saturating count of stall cycles.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   d_valid             decode holds a valid instruction
//   d_src_reg_1/2       decode source register indices
//   x_opcode            execute stage opcode (MUL detection)
//   x_dst_reg           execute stage destination register
//   x_mem_read          execute stage holds a load
//   x_branch_taken      branch resolved taken in execute this cycle
//   m_mem_req           memory stage accessing data memory
//   m_mem_ready         data memory completes the access this cycle
//   f_stall, d_stall    hold PC + fetch/decode register, hold decode
//   fd_flush            zero fetch/decode register at next edge
//   dx_bubble           inject all-zero NOP into decode/execute register
//   dx_hold             hold decode/execute register
//   x_hold              hold execute/memory register (memory freeze)
//   mul_done            final execute cycle of a MUL
//   stall_cycles        saturating count of cycles with f_stall=1
// ---------------------------------------------------------------------------
module pipeline_controller #(
  parameter int unsigned MUL_LATENCY = 5,
  parameter logic [6:0]  OPC_MUL     = 7'h02
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [5:0]  d_src_reg_1,
  input  logic [5:0]  d_src_reg_2,
  input  logic [6:0]  x_opcode,
  input  logic [5:0]  x_dst_reg,
  input  logic        x_mem_read,
  input  logic        x_branch_taken,
  input  logic        m_mem_req,
  input  logic        m_mem_ready,
  output logic        f_stall,
  output logic        d_stall,
  output logic        fd_flush,
  output logic        dx_bubble,
  output logic        dx_hold,
  output logic        x_hold,
  output logic        mul_done,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_LAST = 2'd2
  } state_t;

  // The detect cycle and MUL_LAST account for two of the MUL_LATENCY cycles;
  // MUL_BUSY counts cnt down to zero, covering the remaining ones.
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 3);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  logic freeze;
  logic load_use;

  assign freeze   = m_mem_req & ~m_mem_ready;
  assign load_use = x_mem_read & d_valid & (x_dst_reg != 6'd0) &
                    ((x_dst_reg == d_src_reg_1) | (x_dst_reg == d_src_reg_2));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f_stall   = 1'b0;
    d_stall   = 1'b0;
    fd_flush  = 1'b0;
    dx_bubble = 1'b0;
    dx_hold   = 1'b0;
    x_hold    = 1'b0;
    mul_done  = 1'b0;

    if (reset) begin
      // Keep the pipeline registers flushed to NOPs while reset is held.
      fd_flush  = 1'b1;
      dx_bubble = 1'b1;
    end else if (freeze) begin
      // Whole front of the pipeline waits on data memory; hazards are
      // re-evaluated once the freeze lifts because their inputs are held.
      f_stall = 1'b1;
      d_stall = 1'b1;
      dx_hold = 1'b1;
      x_hold  = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (x_branch_taken) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
          end else if (x_opcode == OPC_MUL) begin
            f_stall = 1'b1;
            d_stall = 1'b1;
            dx_hold = 1'b1;
            state_d = MUL_BUSY;
            cnt_d   = MUL_CNT_INIT;
          end else if (load_use) begin
            f_stall   = 1'b1;
            d_stall   = 1'b1;
            dx_bubble = 1'b1;
          end
        end
        MUL_BUSY: begin
          f_stall = 1'b1;
          d_stall = 1'b1;
          dx_hold = 1'b1;
          if (cnt_q == 4'd0) begin
            state_d = MUL_LAST;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        MUL_LAST: begin
          // Departing MUL is still in X here; not returning through RUN's
          // detect path keeps it from being seen as a new MUL.
          mul_done = 1'b1;
          state_d  = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (f_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= RUN;
      cnt_q          <= 4'd0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_controller.sv
module tb_pipeline_controller;

  localparam logic [6:0] OPC_MUL = 7'h02;

  logic        clock;
  logic        reset;
  logic        d_valid;
  logic [5:0]  d_src_reg_1;
  logic [5:0]  d_src_reg_2;
  logic [6:0]  x_opcode;
  logic [5:0]  x_dst_reg;
  logic        x_mem_read;
  logic        x_branch_taken;
  logic        m_mem_req;
  logic        m_mem_ready;
  logic        f_stall;
  logic        d_stall;
  logic        fd_flush;
  logic        dx_bubble;
  logic        dx_hold;
  logic        x_hold;
  logic        mul_done;
  logic [31:0] stall_cycles;

  // {f_stall, d_stall, fd_flush, dx_bubble, dx_hold, x_hold, mul_done}
  logic [6:0] ctl;
  assign ctl = {f_stall, d_stall, fd_flush, dx_bubble, dx_hold, x_hold, mul_done};

  localparam logic [6:0] C_IDLE   = 7'b000_0000;
  localparam logic [6:0] C_RESET  = 7'b001_1000;
  localparam logic [6:0] C_BRANCH = 7'b001_1000;
  localparam logic [6:0] C_LDUSE  = 7'b110_1000;
  localparam logic [6:0] C_MUL    = 7'b110_0100;
  localparam logic [6:0] C_FREEZE = 7'b110_0110;
  localparam logic [6:0] C_DONE   = 7'b000_0001;

  int n_checks;
  int n_fail;
  logic [31:0] exp_sc;

  pipeline_controller #(
    .MUL_LATENCY(5),
    .OPC_MUL    (OPC_MUL)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .d_valid       (d_valid),
    .d_src_reg_1   (d_src_reg_1),
    .d_src_reg_2   (d_src_reg_2),
    .x_opcode      (x_opcode),
    .x_dst_reg     (x_dst_reg),
    .x_mem_read    (x_mem_read),
    .x_branch_taken(x_branch_taken),
    .m_mem_req     (m_mem_req),
    .m_mem_ready   (m_mem_ready),
    .f_stall       (f_stall),
    .d_stall       (d_stall),
    .fd_flush      (fd_flush),
    .dx_bubble     (dx_bubble),
    .dx_hold       (dx_hold),
    .x_hold        (x_hold),
    .mul_done      (mul_done),
    .stall_cycles  (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clear_inputs();
    d_valid        = 1'b0;
    d_src_reg_1    = 6'd0;
    d_src_reg_2    = 6'd0;
    x_opcode       = 7'd0;
    x_dst_reg      = 6'd0;
    x_mem_read     = 1'b0;
    x_branch_taken = 1'b0;
    m_mem_req      = 1'b0;
    m_mem_ready    = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #13;
    n_checks++;
    if (ctl !== C_RESET) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected %b", ctl, C_RESET);
    end
    n_checks++;
    if (stall_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", stall_cycles);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_fail++;
      $display("FAIL reset_release_ctl: got %b expected %b", ctl, C_IDLE);
    end
    exp_sc = 32'd0;
  endtask

  task automatic test_load_use();
    @(negedge clock);
    x_mem_read = 1'b1; x_dst_reg = 6'd5; d_valid = 1'b1; d_src_reg_1 = 6'd5;
    #1;
    n_checks++;
    if (ctl !== C_LDUSE) begin
      n_fail++;
      $display("FAIL load_use_src1: got %b expected %b", ctl, C_LDUSE);
    end
    // Bubble has moved into X: the load is gone.
    @(negedge clock);
    x_mem_read = 1'b0; x_dst_reg = 6'd0;
    #1;
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_fail++;
      $display("FAIL load_use_after: got %b expected %b", ctl, C_IDLE);
    end
    exp_sc = exp_sc + 32'd1;
    n_checks++;
    if (stall_cycles !== exp_sc) begin
      n_fail++;
      $display("FAIL load_use_count: got %0d expected %0d", stall_cycles, exp_sc);
    end
    // Destination r0 never creates a hazard.
    @(negedge clock);
    x_mem_read = 1'b1; x_dst_reg = 6'd0; d_src_reg_1 = 6'd0; d_src_reg_2 = 6'd0;
    #1;
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_fail++;
      $display("FAIL load_use_r0: got %b expected %b", ctl, C_IDLE);
    end
    @(negedge clock);
    x_dst_reg = 6'd7; d_src_reg_1 = 6'd1; d_src_reg_2 = 6'd7;
    #1;
    n_checks++;
    if (ctl !== C_LDUSE) begin
      n_fail++;
      $display("FAIL load_use_src2: got %b expected %b", ctl, C_LDUSE);
    end
    @(negedge clock);
    d_valid = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_fail++;
      $display("FAIL load_use_invalid: got %b expected %b", ctl, C_IDLE);
    end
    exp_sc = exp_sc + 32'd1;
    n_checks++;
    if (stall_cycles !== exp_sc) begin
      n_fail++;
      $display("FAIL load_use_count2: got %0d expected %0d", stall_cycles, exp_sc);
    end
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic test_mul();
    @(negedge clock);
    x_opcode = OPC_MUL;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (ctl !== C_MUL) begin
        n_fail++;
        $display("FAIL mul_stall_c%0d: got %b expected %b", c, ctl, C_MUL);
      end
      @(negedge clock);
    end
    x_opcode = 7'd0;
    #1;
    n_checks++;
    if (ctl !== C_DONE) begin
      n_fail++;
      $display("FAIL mul_done_c4: got %b expected %b", ctl, C_DONE);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_fail++;
      $display("FAIL mul_after: got %b expected %b", ctl, C_IDLE);
    end
    exp_sc = exp_sc + 32'd4;
    n_checks++;
    if (stall_cycles !== exp_sc) begin
      n_fail++;
      $display("FAIL mul_count: got %0d expected %0d", stall_cycles, exp_sc);
    end
  endtask

  task automatic test_mul_freeze();
    @(negedge clock);
    x_opcode = OPC_MUL;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (ctl !== C_MUL) begin
        n_fail++;
        $display("FAIL mulfz_stall_c%0d: got %b expected %b", c, ctl, C_MUL);
      end
      @(negedge clock);
    end
    // Now in MUL_BUSY with cnt=1: freeze for three cycles.
    m_mem_req = 1'b1; m_mem_ready = 1'b0;
    for (int c = 2; c < 5; c++) begin
      #1;
      n_checks++;
      if (ctl !== C_FREEZE) begin
        n_fail++;
        $display("FAIL mulfz_freeze_c%0d: got %b expected %b", c, ctl, C_FREEZE);
      end
      @(negedge clock);
    end
    m_mem_req = 1'b0;
    for (int c = 5; c < 7; c++) begin
      #1;
      n_checks++;
      if (ctl !== C_MUL) begin
        n_fail++;
        $display("FAIL mulfz_resume_c%0d: got %b expected %b", c, ctl, C_MUL);
      end
      @(negedge clock);
    end
    x_opcode = 7'd0;
    #1;
    n_checks++;
    if (ctl !== C_DONE) begin
      n_fail++;
      $display("FAIL mulfz_done_c7: got %b expected %b", ctl, C_DONE);
    end
    @(negedge clock);
    #1;
    exp_sc = exp_sc + 32'd7;
    n_checks++;
    if (stall_cycles !== exp_sc) begin
      n_fail++;
      $display("FAIL mulfz_count: got %0d expected %0d", stall_cycles, exp_sc);
    end
    // Request completing in the same cycle is not a freeze.
    m_mem_req = 1'b1; m_mem_ready = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_fail++;
      $display("FAIL mem_ready_no_freeze: got %b expected %b", ctl, C_IDLE);
    end
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic test_branch();
    @(negedge clock);
    x_branch_taken = 1'b1;
    x_mem_read = 1'b1; x_dst_reg = 6'd9; d_valid = 1'b1; d_src_reg_1 = 6'd9;
    #1;
    n_checks++;
    if (ctl !== C_BRANCH) begin
      n_fail++;
      $display("FAIL branch_over_load_use: got %b expected %b", ctl, C_BRANCH);
    end
    @(negedge clock);
    clear_inputs();
    #1;
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_fail++;
      $display("FAIL branch_after: got %b expected %b", ctl, C_IDLE);
    end
    n_checks++;
    if (stall_cycles !== exp_sc) begin
      n_fail++;
      $display("FAIL branch_count: got %0d expected %0d", stall_cycles, exp_sc);
    end
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clock);
    x_opcode = OPC_MUL;
    @(negedge clock);
    @(negedge clock);
    // MUL_BUSY, cnt=1
    #1;
    n_checks++;
    if (ctl !== C_MUL) begin
      n_fail++;
      $display("FAIL rstmul_busy: got %b expected %b", ctl, C_MUL);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (ctl !== C_RESET || stall_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL rstmul_during: got ctl=%b cnt=%0d expected ctl=%b cnt=0",
               ctl, stall_cycles, C_RESET);
    end
    #1;
    reset = 1'b0;
    x_opcode = 7'd0;
    exp_sc = 32'd0;
    @(negedge clock);
    #1;
    n_checks++;
    if (ctl !== C_IDLE) begin
      n_fail++;
      $display("FAIL rstmul_run: got %b expected %b", ctl, C_IDLE);
    end
    n_checks++;
    if (stall_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL rstmul_count: got %0d expected 0", stall_cycles);
    end
  endtask

  task automatic test_saturation();
    @(negedge clock);
    m_mem_req = 1'b1; m_mem_ready = 1'b0;
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      n_checks++;
      if (stall_cycles !== 32'hFFFF_FFFF) begin
        n_fail++;
        $display("FAIL sat_c%0d: got %h expected ffffffff", c, stall_cycles);
      end
    end
    m_mem_req = 1'b0;
    @(negedge clock);
    #1;
    n_checks++;
    if (ctl !== C_IDLE || stall_cycles !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL sat_hold: got ctl=%b cnt=%h expected ctl=%b cnt=ffffffff",
               ctl, stall_cycles, C_IDLE);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_sc   = 32'd0;
    test_reset();
    test_load_use();
    test_mul();
    test_mul_freeze();
    test_branch();
    test_reset_mid_mul();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
